seg_count_display: RTL and testbench
====================================

SEG_COUNT_DISPLAY -- requirements
Module: seg_count_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (range 1..8).
REQ-002 SHALL have parameter TICK_CYCLES, default 100_000_000, clocks per count increment.
REQ-003 SHALL have parameter SCAN_CYCLES, default 200, clocks each digit is held selected.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, clocks of stable input needed to accept a button level.
REQ-005 SHALL have parameter ACTIVE_LOW, default 1; 1 inverts sel and seg at the output.
REQ-006 SHALL have parameter BLANK_LZ, default 1; 1 enables leading-zero blanking.
REQ-007 SHALL have port clk  input  1  single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-009 SHALL have port mode_btn  input  1  raw asynchronous button, active-high; each press toggles between decimal and hex.
REQ-010 SHALL have port count_en  input  1  1 = counting runs, 0 = prescaler and count hold.
REQ-011 SHALL have port sel  output  NUM_DIGITS  one-hot digit select; bit 0 = least-significant digit.
REQ-012 SHALL have port seg  output  8  segments: bit0=a .. bit6=g, bit7=dp.
REQ-013 SHALL have port hex_mode  output  1  current mode: 0 = decimal (BCD), 1 = hex.
REQ-014 SHALL have port wrap  output  1  one-cycle pulse when the count rolls over to zero.
REQ-015 SHALL have port tick_dbg  output  1  toggles on every count tick.

Function
REQ-016 mode_btn SHALL pass through a 2-flop synchronizer and then a debouncer; the debounced level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-017 A press SHALL be a 0->1 edge of the debounced level; hex_mode SHALL toggle on the cycle after that edge.
REQ-018 A mode toggle SHALL clear every digit to 0 and the prescaler to 0 in the same cycle; wrap SHALL NOT pulse.
REQ-019 Prescaler: with count_en=1 it counts 0..TICK_CYCLES-1; at TICK_CYCLES-1 it returns to 0 and issues a one-cycle tick; with count_en=0 it holds its value.
REQ-020 On tick the count SHALL increment by 1 as a NUM_DIGITS-digit number with 4-bit digits, radix 10 (hex_mode=0) or radix 16 (hex_mode=1), with carry ripple-through in the same cycle.
REQ-021 When all digits are at radix-1 and a tick occurs, all digits SHALL become 0 and wrap SHALL be 1 for exactly that following cycle.
REQ-022 When a tick and a mode toggle occur in the same cycle, the toggle SHALL win: count cleared, tick discarded, no wrap.
REQ-023 Scan: a scan counter runs 0..SCAN_CYCLES-1 independently of count_en; at its terminal value the digit index advances, NUM_DIGITS-1 wrapping to 0.
REQ-024 sel and seg SHALL be registered; they reflect the current digit index and digit value with 1-cycle latency.
REQ-025 Segment decode SHALL be the standard 0-F glyph table (0=0x3F, 1=0x06, ... 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71), before polarity.
REQ-026 When BLANK_LZ=1, digit i>0 SHALL display all segments off if it and every higher digit are 0; digit 0 SHALL never be blanked; sel still asserts for the blanked digit.
REQ-027 dp (seg[7]) SHALL be on only on digit 0 while hex_mode=1.
REQ-028 With ACTIVE_LOW=1, sel and seg SHALL be bitwise inverted after the registers (inactive level = 1).

Reset
REQ-029 With rst_n=0, immediately and regardless of clk: count=0, hex_mode=0, prescaler=0, scan counter=0, digit index=0, debouncer state=0, wrap=0, tick_dbg=0, sel and seg all at inactive level.
REQ-030 Reset asserted mid-count or mid-debounce SHALL abort the operation with no pending toggle or wrap after release.

Structure
REQ-031 Package seg_pkg SHALL hold the 16-entry glyph table constant, the dp bit index, and the mode encoding constants.
REQ-032 The synchronizer plus debouncer SHALL be one sub-module, btn_debounce, parameterised by DEBOUNCE_CYCLES; everything else stays in seg_count_display.

Verification (bench uses NUM_DIGITS=2, TICK_CYCLES=4, SCAN_CYCLES=3, DEBOUNCE_CYCLES=5, ACTIVE_LOW=0)
REQ-033 Decimal rollover: count_en=1 for 100 ticks from reset -> count goes 00..99 then 00; wrap pulses once, one cycle long, exactly at 99->00.
REQ-034 Hex mode: one clean press, then 255 ticks -> hex_mode=1, count=FF, digit 0 seg=0x71|0x80, digit 1 seg=0x71; the next tick gives 00 plus a wrap pulse.
REQ-035 Bounce: mode_btn high for 3 cycles, low for 2, high for 4 -> no toggle; then high held for 7 or more cycles -> exactly one toggle, and count is cleared.
REQ-036 Collision: press timed so the toggle cycle coincides with a tick at count 07 -> count=00, no wrap, mode flipped.
REQ-037 Blanking and scan: count=05 -> sel alternates 01/10 every 3 cycles; digit 1 seg=0x00, digit 0 seg=0x6D; count_en=0 for 20 cycles leaves the count unchanged.
REQ-038 Reset mid-operation: rst_n low at count 42 with a press half-debounced -> all outputs at reset values asynchronously; after release count=00, hex_mode=0, no toggle.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment counter display.
//   mode_e    : display radix encoding (decimal BCD / hexadecimal)
//   DP_BIT    : position of the decimal-point segment in a seg byte
//   SEG_GLYPH : active-high glyphs for 0-F, bit0=a .. bit6=g, dp clear
package seg_pkg;

    typedef enum logic {
        MODE_DEC = 1'b0,
        MODE_HEX = 1'b1
    } mode_e;

    localparam int DP_BIT = 7;

    localparam logic [15:0][7:0] SEG_GLYPH = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer followed by a counting debouncer.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_btn      : raw asynchronous button level
//   o_level    : debounced level, changes after DEBOUNCE_CYCLES
//                consecutive synchronized samples that differ from it
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_level
);

    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;

    // Counter measures how long the synchronized input has disagreed with
    // the accepted level; any agreeing sample restarts the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/seg_count_display.sv
// seg_count_display: free-running decimal/hex counter shown on a multiplexed
// seven-segment display.
//   clk, rst_n : clock, asynchronous active-low reset
//   mode_btn   : raw button; each debounced press toggles decimal/hex
//   count_en   : 1 runs the prescaler and count, 0 holds them
//   sel        : one-hot digit select, bit 0 = least-significant digit
//   seg        : segments a..g in bits 0..6, dp in bit 7
//   hex_mode   : 0 decimal, 1 hex
//   wrap       : one-cycle pulse when the count rolls over to zero
//   tick_dbg   : toggles on every accepted count tick
module seg_count_display
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int TICK_CYCLES     = 100_000_000,
    parameter int SCAN_CYCLES     = 200,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter bit ACTIVE_LOW      = 1,
    parameter bit BLANK_LZ        = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode_btn,
    input  logic                  count_en,
    output logic [NUM_DIGITS-1:0] sel,
    output logic [7:0]            seg,
    output logic                  hex_mode,
    output logic                  wrap,
    output logic                  tick_dbg
);

    localparam int PW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
    localparam int SW = SCAN_CYCLES > 1 ? $clog2(SCAN_CYCLES) : 1;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    logic                       w_db_level;
    logic                       w_press;
    logic                       w_tick;
    logic                       w_all_max;
    logic [3:0]                 w_max;
    logic [NUM_DIGITS-1:0][3:0] w_next;
    logic [7:0]                 w_seg;

    logic                       r_db_prev;
    mode_e                      r_mode;
    logic [PW-1:0]              r_presc;
    logic [NUM_DIGITS-1:0][3:0] r_digits;
    logic                       r_wrap;
    logic                       r_tick_dbg;
    logic [SW-1:0]              r_scan;
    logic [IW-1:0]              r_idx;
    logic [NUM_DIGITS-1:0]      r_sel;
    logic [7:0]                 r_seg;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (mode_btn),
        .o_level(w_db_level)
    );

    assign w_press = w_db_level & ~r_db_prev;
    assign w_tick  = count_en && (r_presc == PW'(TICK_CYCLES - 1));
    assign w_max   = (r_mode == MODE_HEX) ? 4'hF : 4'd9;

    // Ripple-carry increment; the final carry means every digit was at
    // radix-1, i.e. this tick rolls the count over.
    always_comb begin : incr
        logic c;
        c = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_next[i] = (c && r_digits[i] == w_max) ? 4'd0 : r_digits[i] + {3'd0, c};
            c = c & (r_digits[i] == w_max);
        end
        w_all_max = c;
    end

    // A digit above 0 is blanked when it and all higher digits are zero.
    always_comb begin : disp
        logic nz;
        logic blank;
        nz = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (i >= int'(r_idx)) nz = nz | (r_digits[i] != 4'd0);
        blank = BLANK_LZ && (r_idx != '0) && !nz;
        w_seg = '0;
        if (!blank) begin
            w_seg         = SEG_GLYPH[r_digits[r_idx]];
            w_seg[DP_BIT] = (r_mode == MODE_HEX) && (r_idx == '0);
        end
    end

    // A mode toggle clears the count and prescaler and swallows any tick
    // arriving in the same cycle, so no wrap can come out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_prev  <= 1'b0;
            r_mode     <= MODE_DEC;
            r_presc    <= '0;
            r_digits   <= '0;
            r_wrap     <= 1'b0;
            r_tick_dbg <= 1'b0;
        end else begin
            r_db_prev <= w_db_level;
            r_wrap    <= 1'b0;
            if (w_press) begin
                r_mode   <= (r_mode == MODE_HEX) ? MODE_DEC : MODE_HEX;
                r_digits <= '0;
                r_presc  <= '0;
            end else begin
                if (count_en) r_presc <= w_tick ? '0 : r_presc + 1'b1;
                if (w_tick) begin
                    r_digits   <= w_next;
                    r_wrap     <= w_all_max;
                    r_tick_dbg <= ~r_tick_dbg;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan <= '0;
            r_idx  <= '0;
        end else if (r_scan == SW'(SCAN_CYCLES - 1)) begin
            r_scan <= '0;
            r_idx  <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_scan <= r_scan + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= '0;
            r_seg <= '0;
        end else begin
            r_sel <= NUM_DIGITS'(1) << r_idx;
            r_seg <= w_seg;
        end
    end

    assign sel      = ACTIVE_LOW ? ~r_sel : r_sel;
    assign seg      = ACTIVE_LOW ? ~r_seg : r_seg;
    assign hex_mode = (r_mode == MODE_HEX);
    assign wrap     = r_wrap;
    assign tick_dbg = r_tick_dbg;

endmodule

// File: tb/tb_seg_count_display.sv
// tb_seg_count_display: directed and random stimulus for seg_count_display
// compared every cycle against an arithmetic reference model.
module tb_seg_count_display;

    localparam int N  = 2;
    localparam int TK = 4;
    localparam int SC = 3;
    localparam int DB = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         mode_btn = 1'b0;
    logic         count_en = 1'b0;
    logic [N-1:0] sel;
    logic [7:0]   seg;
    logic         hex_mode;
    logic         wrap;
    logic         tick_dbg;

    seg_count_display #(
        .NUM_DIGITS(N), .TICK_CYCLES(TK), .SCAN_CYCLES(SC),
        .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(0), .BLANK_LZ(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode_btn(mode_btn), .count_en(count_en),
        .sel(sel), .seg(seg), .hex_mode(hex_mode), .wrap(wrap), .tick_dbg(tick_dbg)
    );

    always #5 clk = ~clk;

    logic [7:0] glyph [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    int checks = 0;
    int errors = 0;

    int   m_count, m_presc, m_k;
    bit   m_hex, m_wrap, m_tdbg, m_db, m_db_prev;
    bit   bq[$];
    bit   sq[$];
    logic [N-1:0] exp_sel;
    logic [7:0]   exp_seg;

    int         wrap_seen, tog_seen;
    logic       prev_hex;
    logic [7:0] seen0, seen1;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] disp(int cnt, bit hx, int idx);
        int r = hx ? 16 : 10;
        int v = cnt;
        for (int j = 0; j < idx; j++) v = v / r;
        if (idx > 0 && v == 0) return 8'h00;
        return glyph[v % r] | ((hx && idx == 0) ? 8'h80 : 8'h00);
    endfunction

    task automatic model_reset();
        m_count = 0; m_presc = 0; m_k = 0;
        m_hex = 0; m_wrap = 0; m_tdbg = 0; m_db = 0; m_db_prev = 0;
        bq.delete();
        sq.delete();
        prev_hex = 1'b0;
    endtask

    // One rising edge: display shows the pre-edge count on the pre-edge
    // digit; button reaches the debouncer two edges late and must hold a
    // new level for DB synchronized samples; press is acted on one edge
    // after the debounced rise.
    task automatic model_edge();
        int  idx, md;
        bit  syn, all_diff, press, tick;
        idx     = (m_k / SC) % N;
        exp_sel = N'(1) << idx;
        exp_seg = disp(m_count, m_hex, idx);
        m_k++;
        bq.push_back(mode_btn);
        if (bq.size() > 8) void'(bq.pop_front());
        syn = (bq.size() >= 3) ? bq[bq.size() - 3] : 1'b0;
        sq.push_back(syn);
        if (sq.size() > DB) void'(sq.pop_front());
        all_diff = (sq.size() == DB);
        foreach (sq[j]) if (sq[j] == m_db) all_diff = 0;
        press     = m_db && !m_db_prev;
        m_db_prev = m_db;
        if (all_diff) m_db = !m_db;
        m_wrap = 0;
        tick   = count_en && (m_presc == TK - 1);
        md     = (m_hex ? 16 : 10) ** N;
        if (press) begin
            m_hex   = !m_hex;
            m_count = 0;
            m_presc = 0;
        end else begin
            if (count_en) m_presc = (m_presc + 1) % TK;
            if (tick) begin
                m_count = (m_count + 1) % md;
                m_wrap  = (m_count == 0);
                m_tdbg  = !m_tdbg;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("sel", sel, exp_sel);
        chk("seg", seg, exp_seg);
        chk("hex_mode", hex_mode, m_hex);
        chk("wrap", wrap, m_wrap);
        chk("tick_dbg", tick_dbg, m_tdbg);
        wrap_seen += int'(wrap);
        if (hex_mode !== prev_hex) tog_seen++;
        prev_hex = hex_mode;
        if (sel == 2'b01) seen0 = seg;
        else if (sel == 2'b10) seen1 = seg;
    endtask

    task automatic run(int n);
        repeat (n) cyc();
    endtask

    task automatic press();
        mode_btn = 1'b1;
        run(8);
        mode_btn = 1'b0;
        run(10);
    endtask

    task automatic run_until_count(int target, int presc, int budget, string tag);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            if (m_count == target && (presc < 0 || m_presc == presc)) found = 1;
            else cyc();
        end
        if (!found) chk(tag, 0, 1);
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_sel"}, sel, 0);
        chk({tag, "_seg"}, seg, 0);
        chk({tag, "_hex"}, hex_mode, 0);
        chk({tag, "_wrap"}, wrap, 0);
        chk({tag, "_tick"}, tick_dbg, 0);
    endtask

    initial begin
        logic h;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // decimal rollover 00..99 -> 00
        count_en  = 1'b1;
        wrap_seen = 0;
        run(401);
        chk("dec_wrap_count", wrap_seen, 1);
        count_en = 1'b0;

        // hex mode up to FF then rollover
        press();
        chk("hex_after_press", hex_mode, 1);
        count_en = 1'b1;
        run(TK * 255);
        count_en = 1'b0;
        run(6);
        chk("ff_digit0", seen0, 8'hF1);
        chk("ff_digit1", seen1, 8'h71);
        wrap_seen = 0;
        count_en  = 1'b1;
        run(TK);
        count_en = 1'b0;
        chk("hex_wrap_now", wrap, 1);
        run(1);
        chk("hex_wrap_gone", wrap, 0);
        chk("hex_wrap_count", wrap_seen, 1);

        // bouncing button: no toggle, then a held press toggles once
        tog_seen = 0;
        count_en = 1'b1;
        mode_btn = 1'b1; run(3);
        mode_btn = 1'b0; run(2);
        mode_btn = 1'b1; run(4);
        mode_btn = 1'b0; run(10);
        chk("bounce_no_toggle", tog_seen, 0);
        press();
        chk("held_one_toggle", tog_seen, 1);

        // toggle lands on the tick that would take 07 -> 08
        run_until_count(6, 0, 200, "collision_setup_timeout");
        h         = hex_mode;
        wrap_seen = 0;
        mode_btn  = 1'b1;
        run(8);
        chk("coll_mode", hex_mode, !m_hex ? 0 : 1);
        chk("coll_flipped", hex_mode ^ h, 1);
        chk("coll_no_wrap", wrap_seen, 0);
        count_en = 1'b0;
        mode_btn = 1'b0;
        run(10);
        chk("coll_digit0", seen0, 8'h3F | (m_hex ? 8'h80 : 8'h00));
        chk("coll_digit1", seen1, 8'h00);

        // back to decimal, count to 05, hold with count_en low
        press();
        chk("blank_mode_dec", hex_mode, 0);
        count_en = 1'b1;
        run_until_count(5, -1, 100, "blank_setup_timeout");
        count_en = 1'b0;
        run(20);
        chk("blank_digit0", seen0, 8'h6D);
        chk("blank_digit1", seen1, 8'h00);

        // async reset at 42 with a half-debounced press
        count_en = 1'b1;
        run_until_count(42, -1, 300, "reset_setup_timeout");
        count_en = 1'b0;
        mode_btn = 1'b1;
        run(4);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        mode_btn = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tog_seen = 0;
        run(20);
        chk("post_reset_hex", hex_mode, 0);
        chk("post_reset_toggles", tog_seen, 0);
        chk("post_reset_digit0", seen0, 8'h3F);
        chk("post_reset_digit1", seen1, 8'h00);

        // random enable and button activity
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) mode_btn = ~mode_btn;
            count_en = ($urandom_range(0, 9) != 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
